// File: rtl/ps2_pkg.sv
// ps2_pkg: scancode constants, FSM encoding and ASCII default shared by the PS/2 key tracker
package ps2_pkg;
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] ASCII_NONE = 8'h00;
  typedef enum logic [1:0] {IDLE, POP, WAIT, DECODE} state_t;
endpackage

// File: rtl/ps2_ascii_lut.sv
// ps2_ascii_lut: combinational set-2 scancode to lowercase ASCII (a-z, 0-9, space, enter; else 0x00)
//   code  : set-2 make scancode
//   ascii : lowercase ASCII, ASCII_NONE when unmapped
module ps2_ascii_lut
  import ps2_pkg::*;
(
  input  logic [7:0] code,
  output logic [7:0] ascii
);
  always_comb begin
    ascii = ASCII_NONE;
    case (code)
      8'h1C: ascii = 8'h61;
      8'h32: ascii = 8'h62;
      8'h21: ascii = 8'h63;
      8'h23: ascii = 8'h64;
      8'h24: ascii = 8'h65;
      8'h2B: ascii = 8'h66;
      8'h34: ascii = 8'h67;
      8'h33: ascii = 8'h68;
      8'h43: ascii = 8'h69;
      8'h3B: ascii = 8'h6A;
      8'h42: ascii = 8'h6B;
      8'h4B: ascii = 8'h6C;
      8'h3A: ascii = 8'h6D;
      8'h31: ascii = 8'h6E;
      8'h44: ascii = 8'h6F;
      8'h4D: ascii = 8'h70;
      8'h15: ascii = 8'h71;
      8'h2D: ascii = 8'h72;
      8'h1B: ascii = 8'h73;
      8'h2C: ascii = 8'h74;
      8'h3C: ascii = 8'h75;
      8'h2A: ascii = 8'h76;
      8'h1D: ascii = 8'h77;
      8'h22: ascii = 8'h78;
      8'h35: ascii = 8'h79;
      8'h1A: ascii = 8'h7A;
      8'h45: ascii = 8'h30;
      8'h16: ascii = 8'h31;
      8'h1E: ascii = 8'h32;
      8'h26: ascii = 8'h33;
      8'h25: ascii = 8'h34;
      8'h2E: ascii = 8'h35;
      8'h36: ascii = 8'h36;
      8'h3D: ascii = 8'h37;
      8'h3E: ascii = 8'h38;
      8'h46: ascii = 8'h39;
      8'h29: ascii = 8'h20;
      8'h5A: ascii = 8'h0D;
      default: ascii = ASCII_NONE;
    endcase
  end
endmodule

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: decodes PS/2 set-2 make/break/E0 byte stream into held-key state and a decimal press count
//   clk, resetn (async, active low); kbd_data/kbd_ready/kbd_overflow from the receiver FIFO,
//   kbd_nextdata_n one-cycle active-low pop; key_code/key_ascii/key_valid/key_ext held-key state;
//   cnt_ones/cnt_tens press count (wraps after CNT_MAX); ovf_seen sticky overflow flag.
//   Define PS2_KEY_EXT_EN to track the E0 prefix; otherwise E0 is discarded and key_ext is 0.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int CNT_MAX = 99
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] kbd_data,
  input  logic       kbd_ready,
  input  logic       kbd_overflow,
  output logic       kbd_nextdata_n,
  output logic [7:0] key_code,
  output logic [7:0] key_ascii,
  output logic       key_valid,
  output logic       key_ext,
  output logic [3:0] cnt_ones,
  output logic [3:0] cnt_tens,
  output logic       ovf_seen
);
  localparam logic [3:0] TENS_MAX = 4'(CNT_MAX / 10);
  localparam logic [3:0] ONES_MAX = 4'(CNT_MAX % 10);
  state_t state, state_nx;
  logic [7:0] byte_r, lut_ascii;
  logic break_pend, ext_p, pop, dec, data, match, bump, rel, wrap;
  ps2_ascii_lut u_lut (.code(byte_r), .ascii(lut_ascii));
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (kbd_ready ? POP : IDLE) :
               state == POP ? WAIT : state == WAIT ? DECODE : IDLE;
  always_comb begin
    pop = state == IDLE && kbd_ready;
    dec = state == DECODE;
    data = dec && byte_r != PS2_BREAK && byte_r != PS2_EXT;
    match = key_valid && byte_r == key_code && ext_p == key_ext;
    bump = data && !break_pend && !match;
    rel = data && break_pend && match;
    wrap = cnt_tens == TENS_MAX && cnt_ones == ONES_MAX;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      kbd_nextdata_n <= 1'b1;
      byte_r <= 8'h00;
      break_pend <= 1'b0;
      key_code <= 8'h00;
      key_ascii <= ASCII_NONE;
      key_valid <= 1'b0;
      cnt_ones <= 4'd0;
      cnt_tens <= 4'd0;
      ovf_seen <= 1'b0;
    end else begin
      kbd_nextdata_n <= !pop;
      if (pop) byte_r <= kbd_data;
      if (kbd_overflow) ovf_seen <= 1'b1;
      // an E0 between F0 and the code (E0 F0 xx or F0 E0 xx) must not cancel the pending break
      if (dec) break_pend <= byte_r == PS2_BREAK || (byte_r == PS2_EXT && break_pend);
      if (rel) key_valid <= 1'b0;
      if (bump) begin
        key_code <= byte_r;
        key_valid <= 1'b1;
        key_ascii <= ext_p ? ASCII_NONE : lut_ascii;
        cnt_ones <= wrap || cnt_ones == 4'd9 ? 4'd0 : cnt_ones + 4'd1;
        cnt_tens <= wrap ? 4'd0 : cnt_ones == 4'd9 ? cnt_tens + 4'd1 : cnt_tens;
      end
    end
`ifdef PS2_KEY_EXT_EN
  logic ext_pend;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      ext_pend <= 1'b0;
      key_ext <= 1'b0;
    end else if (dec) begin
      ext_pend <= byte_r == PS2_EXT || (byte_r == PS2_BREAK && ext_pend);
      if (bump) key_ext <= ext_pend;
    end
  assign ext_p = ext_pend;
`else
  assign ext_p = 1'b0;
  assign key_ext = 1'b0;
`endif
endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb_ps2_key_tracker: scoreboard bench with a FIFO-style receiver model and a behavioural key-state model
module tb_ps2_key_tracker;
`ifdef PS2_KEY_EXT_EN
  localparam bit EXT_EN = 1'b1;
`else
  localparam bit EXT_EN = 1'b0;
`endif
  logic clk = 1'b0, resetn = 1'b0, kbd_ready = 1'b0, kbd_overflow = 1'b0;
  logic [7:0] kbd_data = 8'h00;
  logic kbd_nextdata_n, key_valid, key_ext, ovf_seen;
  logic [7:0] key_code, key_ascii;
  logic [3:0] cnt_ones, cnt_tens;
  typedef struct {
    logic [7:0] code;
    logic [7:0] ascii;
    logic valid;
    logic ext;
    int count;
  } exp_t;
  exp_t exp_q[$];
  logic [7:0] fifo[$];
  int n_chk = 0, n_pass = 0, n_sent = 0, n_pulse = 0;
  logic m_valid, m_ext, m_brk, m_xp;
  logic [7:0] m_code, m_ascii;
  int m_cnt;
  logic [7:0] letters[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                              8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                              8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digits[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] pool[10] = '{8'hF0, 8'hE0, 8'h1C, 8'h32, 8'h16, 8'h1E, 8'h24, 8'h29, 8'h5A, 8'h75};
  ps2_key_tracker dut (
    .clk(clk), .resetn(resetn), .kbd_data(kbd_data), .kbd_ready(kbd_ready),
    .kbd_overflow(kbd_overflow), .kbd_nextdata_n(kbd_nextdata_n), .key_code(key_code),
    .key_ascii(key_ascii), .key_valid(key_valid), .key_ext(key_ext),
    .cnt_ones(cnt_ones), .cnt_tens(cnt_tens), .ovf_seen(ovf_seen)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] ascii_of(input logic [7:0] c);
    for (int i = 0; i < 26; i++) if (letters[i] == c) return 8'h61 + 8'(i);
    for (int i = 0; i < 10; i++) if (digits[i] == c) return 8'h30 + 8'(i);
    if (c == 8'h29) return 8'h20;
    if (c == 8'h5A) return 8'h0D;
    return 8'h00;
  endfunction
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
  endtask
  task automatic model_reset();
    m_valid = 0; m_ext = 0; m_brk = 0; m_xp = 0; m_code = 0; m_ascii = 0; m_cnt = 0;
  endtask
  task automatic model(input logic [7:0] b);
    exp_t e;
    bit same;
    if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) begin
      if (EXT_EN) m_xp = 1;
    end else begin
      same = m_valid && b == m_code && m_xp == m_ext;
      if (m_brk) begin
        if (same) m_valid = 0;
      end else if (!same) begin
        m_code = b; m_ext = m_xp; m_valid = 1;
        m_ascii = m_xp ? 8'h00 : ascii_of(b);
        m_cnt = (m_cnt + 1) % 100;
      end
      m_brk = 0; m_xp = 0;
    end
    e.code = m_code; e.ascii = m_ascii; e.valid = m_valid; e.ext = m_ext; e.count = m_cnt;
    exp_q.push_back(e);
  endtask
  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
    n_sent++;
  endtask
  task automatic drain();
    int n = 0;
    while ((fifo.size() != 0 || exp_q.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    if (n >= 5000) begin
      n_chk++;
      $display("FAIL drain_timeout: fifo %0d expected %0d pending", fifo.size(), exp_q.size());
    end
  endtask
  task automatic check_reset(input string tag);
    chk({tag, "_nextdata_n"}, 8'(kbd_nextdata_n), 8'd1);
    chk({tag, "_key_code"}, key_code, 8'h00);
    chk({tag, "_key_ascii"}, key_ascii, 8'h00);
    chk({tag, "_key_valid"}, 8'(key_valid), 8'd0);
    chk({tag, "_key_ext"}, 8'(key_ext), 8'd0);
    chk({tag, "_cnt_ones"}, 8'(cnt_ones), 8'd0);
    chk({tag, "_cnt_tens"}, 8'(cnt_tens), 8'd0);
    chk({tag, "_ovf_seen"}, 8'(ovf_seen), 8'd0);
  endtask
  // receiver FIFO: pops on the cycle the strobe is low, presents the head byte otherwise
  initial forever begin
    @(negedge clk);
    if (!kbd_nextdata_n) begin
      if (fifo.size() == 0) begin
        n_chk++;
        $display("FAIL pop_empty: strobe low with empty fifo at %0t", $time);
      end else model(fifo.pop_front());
    end
    kbd_ready = fifo.size() != 0;
    kbd_data = fifo.size() != 0 ? fifo[0] : 8'h00;
  end
  // monitor: each pop strobe yields one decoded result three edges later
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!kbd_nextdata_n) begin
      n_pulse++;
      @(negedge clk);
      chk("pulse_width", 8'(kbd_nextdata_n), 8'd1);
      repeat (2) @(negedge clk);
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL no_expected: decode with empty scoreboard at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("key_code", key_code, e.code);
        chk("key_ascii", key_ascii, e.ascii);
        chk("key_valid", 8'(key_valid), 8'(e.valid));
        chk("key_ext", 8'(key_ext), 8'(e.ext));
        chk("cnt_ones", 8'(cnt_ones), 8'(e.count % 10));
        chk("cnt_tens", 8'(cnt_tens), 8'(e.count / 10));
      end
    end
  end
  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_reset("reset");
    resetn = 1'b1;
    push(8'h1C); push(8'hF0); push(8'h1C);
    drain();
    chk("pulses_after_first", 8'(n_pulse), 8'd3);
    repeat (5) push(8'h32);
    push(8'hF0); push(8'h32);
    drain();
    for (int i = 0; i < 100; i++) begin
      push(i[0] ? 8'h1E : 8'h16); push(8'hF0); push(i[0] ? 8'h1E : 8'h16);
    end
    drain();
    push(8'hE0); push(8'h75); push(8'hF0); push(8'h75);
    push(8'hE0); push(8'hF0); push(8'h75);
    drain();
    for (int i = 0; i < 200; i++) begin
      push($urandom_range(0, 7) == 0 ? 8'($urandom) : pool[$urandom_range(0, 9)]);
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(0, 6)) @(negedge clk);
    end
    drain();
    chk("ovf_idle", 8'(ovf_seen), 8'd0);
    kbd_overflow = 1'b1;
    @(negedge clk);
    kbd_overflow = 1'b0;
    repeat (3) @(negedge clk);
    chk("ovf_set", 8'(ovf_seen), 8'd1);
    push(8'h29); push(8'h5A);
    drain();
    chk("ovf_sticky", 8'(ovf_seen), 8'd1);
    push(8'hF0);
    drain();
    resetn = 1'b0;
    model_reset();
    @(negedge clk);
    check_reset("midreset");
    resetn = 1'b1;
    push(8'h24);
    drain();
    chk("after_reset_ascii", key_ascii, 8'h65);
    chk("after_reset_valid", 8'(key_valid), 8'd1);
    n_chk++;
    if (n_pulse == n_sent) n_pass++;
    else $display("FAIL pulse_count: got %0d expected %0d", n_pulse, n_sent);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
- Consumes the byte FIFO of the PS/2 keyboard receiver and decodes set-2 make/break/extended sequences into a held-key state.
- Produces the current key's scancode and lowercase ASCII, plus a decimal press count split into ones/tens for the 7-segment driver.
- Sits directly downstream of ps2_keyboard and upstream of seg.

Parameters:
- CNT_MAX, 99, press counter terminal value (wraps to 0 after it); must be ≤ 99.

Ports:
- clk  input  1  system clock, same domain as ps2_keyboard
- resetn  input  1  asynchronous active-low reset
- kbd_data  input  8  head byte of the receiver FIFO
- kbd_ready  input  1  FIFO non-empty
- kbd_overflow  input  1  receiver FIFO overflow flag
- kbd_nextdata_n  output  1  active-low pop strobe to the receiver, one cycle wide
- key_code  output  8  scancode of the currently/last held key
- key_ascii  output  8  lowercase ASCII of key_code, 0x00 if unmapped
- key_valid  output  1  a key is currently held
- key_ext  output  1  current key was E0-prefixed
- cnt_ones  output  4  press count mod 10
- cnt_tens  output  4  press count div 10
- ovf_seen  output  1  sticky: kbd_overflow was ever sampled high

Behaviour:
- Reset (async, resetn=0):
  - Outputs: kbd_nextdata_n=1, key_code=0, key_ascii=0, key_valid=0, key_ext=0, cnt_ones=0, cnt_tens=0, ovf_seen=0.
  - Internal: break_pend=0, ext_pend=0, FSM=IDLE.
- FSM states IDLE, POP, WAIT, DECODE:
  - IDLE: if kbd_ready=1, latch kbd_data into byte_r, drive kbd_nextdata_n=0 this cycle (registered output), go POP.
  - POP: kbd_nextdata_n back to 1; go WAIT.
  - WAIT: one dead cycle so the receiver read pointer and kbd_ready settle; go DECODE.
  - DECODE: apply the decode rules below; go IDLE.
- Throughput and latency:
  - At most one byte per 4 cycles. kbd_nextdata_n is never low for two consecutive cycles.
  - Outputs update on the clock edge ending DECODE, i.e. 3 cycles after the pop cycle.
- Decode rules:
  - byte_r==0xF0: break_pend=1.
  - byte_r==0xE0: ext_pend=1.
  - Any other byte with break_pend=1:
    - If key_valid && byte_r==key_code && ext_pend==key_ext, clear key_valid. key_code, key_ascii and key_ext hold their last values.
    - Otherwise ignore (release of a non-tracked key).
    - In both cases clear break_pend and ext_pend.
  - Any other byte with break_pend=0:
    - If key_valid && byte_r==key_code && ext_pend==key_ext, treat as typematic repeat: no state change except clearing ext_pend. Counter does not advance.
    - Otherwise new press: key_code=byte_r, key_ext=ext_pend, key_valid=1, key_ascii=lut(byte_r) (0x00 if key_ext=1), counter +1, clear ext_pend.
- Counter:
  - cnt_ones/cnt_tens form a decimal counter.
  - At value CNT_MAX, the next increment gives 0/0.
  - Ones roll 9→0 with a tens carry.
- ovf_seen is set in any cycle kbd_overflow=1. Only reset clears it.
- Simultaneous events: kbd_ready is sampled only in IDLE; bytes arriving during POP/WAIT/DECODE stay in the receiver FIFO.
- Reset mid-sequence (e.g. after F0): all pending flags clear, and the next byte decodes as a fresh make.

Optional Feature:
- Macro PS2_KEY_EXT_EN.
- Defined: E0 prefix handled as above; key_ext is driven.
- Undefined:
  - 0xE0 bytes are popped and discarded with no effect on break_pend.
  - key_ext is tied to 0, and ext_pend is not implemented.
  - Extended keys alias onto their base scancode.

Decomposition:
- Package ps2_pkg holds:
  - scancode constants PS2_BREAK=8'hF0 and PS2_EXT=8'hE0;
  - the FSM state encoding (IDLE/POP/WAIT/DECODE, 2 bits);
  - ASCII_NONE=8'h00.
- One sub-module, ps2_ascii_lut: combinational set-2 scancode→lowercase ASCII for letters a-z, digits 0-9, space (0x29→0x20) and enter (0x5A→0x0D); everything else maps to 0x00. Its output is registered in the parent.

Test Plan:
- Make 0x1C then F0 1C → key_code=0x1C, key_ascii=0x61, key_valid=1 then 0; cnt_ones=1, cnt_tens=0; exactly 3 single-cycle kbd_nextdata_n pulses for the 3 bytes.
- Typematic 0x32 sent 5 times, then F0 32 → key_ascii=0x62, count advances by exactly 1, key_valid falls only after 0x32 follows F0.
- 100 distinct make/break pairs (alternating 0x16, 0x1E) → count runs 00..99, then wraps to 0/0 on press 100.
- With PS2_KEY_EXT_EN: E0 75 then F0 75 (non-ext) → key_valid stays 1, key_ext=1, key_ascii=0x00. Then E0 F0 75 → key_valid=0.
- Assert resetn=0 after F0 only, release, send 0x24 → treated as make: key_ascii=0x65, key_valid=1.
- Pulse kbd_overflow=1 for one cycle → ovf_seen=1 and it persists until resetn=0.
